mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch side (read-only) and data side (read/write).
- Produces the per-side busy signals that the control unit consumes as InstMemBusy/DataMemBusy.
- Sits between the CPU pipeline and the memory model.
- Handles arbitration, access sequencing, fetch abort on misprediction, and read-data capture.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- LATENCY, 2, memory access cycles per transfer (>=1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_req  input  1  fetch request, held until i_ready or i_abort.
- i_addr  input  ADDR_W  fetch address.
- i_abort  input  1  drop current/pending fetch (misprediction).
- i_ready  output  1  fetch complete pulse; i_rdata valid.
- i_rdata  output  DATA_W  fetched instruction.
- i_busy  output  1  i_req && !i_ready.
- d_read  input  1  data read request, held until d_ready.
- d_write  input  1  data write request, held until d_ready.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_ready  output  1  data access complete pulse.
- d_rdata  output  DATA_W  load data.
- d_busy  output  1  (d_read||d_write) && !d_ready.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid in the last access cycle.

Behaviour:
- FSM states: IDLE, ACCESS.
- Registers: owner (I/D), op (RD/WR), addr, wdata, cnt (clog2(LATENCY+1) bits), and in the round-robin build, last_owner.
- Reset state: IDLE, cnt=0, owner=I.
  - All strobes, ready pulses and busy outputs are 0.
  - i_rdata, d_rdata and mem_addr/mem_wdata are 0.
- IDLE behaviour:
  - If any request is present, latch the winner's address, op and wdata, set cnt=LATENCY-1, and go to ACCESS.
  - No memory strobe is driven in IDLE.
  - The grant decision uses current-cycle inputs only.
- Priority without the optional feature: data side beats fetch, because a data stall freezes the whole pipeline.
- d_read && d_write both high is illegal; write wins and the read is ignored.
- ACCESS behaviour:
  - Drive mem_read or mem_write, with mem_addr/mem_wdata taken from the latched registers, in every ACCESS cycle.
  - If cnt!=0, decrement cnt.
  - If cnt==0, this is the final cycle:
    - Pulse the owner's ready for one cycle.
    - For reads, register mem_rdata into the owner's rdata at this edge, and also pass it through combinationally on rdata in the same cycle.
    - Return to IDLE.
- Timing: a request first seen in IDLE in cycle 0 gets ready in cycle LATENCY. Busy is high in cycles 0..LATENCY-1.
  - A new grant is possible no earlier than cycle LATENCY+1, giving a throughput of 1 access per LATENCY+1 cycles.
- i_abort:
  - If owner==I in ACCESS: deassert mem_read combinationally, go to IDLE at the next edge, and do not pulse i_ready.
  - In IDLE: i_req is ignored that cycle.
  - No effect on a data access.
- A losing requester sees busy=1 every cycle until its own transfer completes.
- rdata holds its last value between transfers.
- Request withdrawn mid-access (other than via i_abort): illegal; the access completes and the ready pulse is still issued.
- Reset asserted mid-access: immediate return to reset state; an in-flight write is lost.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous I and D requests in IDLE, grant the side that did not win the previous grant (last_owner register, reset value D so the first tie goes to I). Aborted fetches count as grants.
- Undefined: fixed data-side priority and no last_owner register.

Decomposition:
- Shared package/include holds:
  - FSM state encodings ST_IDLE=0, ST_ACCESS=1.
  - Owner encodings OWN_I=0, OWN_D=1.
  - Default widths.
- Sub-module: mem_arb_grant, a combinational winner selection (fixed or round-robin per macro). Everything else stays flat.

Test Plan:
- Fetch only, LATENCY=2: i_req=1, i_addr=0x0010, memory returns 0x4A12 → mem_read in cycles 1-2, i_busy=1 in cycles 0-1, i_ready and i_rdata=0x4A12 in cycle 2.
- Simultaneous i_req (addr 0x0020) and d_write (0x0100 ← 0xBEEF), fixed priority:
  - Write occurs in cycles 1-2 with d_ready in cycle 2.
  - Fetch is granted in cycle 3 with i_ready in cycle 5.
  - i_busy=1 in cycles 0-4.
- Same stimulus with MEM_ARB_ROUND_ROBIN_EN defined after reset: fetch is served first (i_ready in cycle 2), then the write (d_ready in cycle 5).
- i_abort in cycle 1 of a fetch to 0x0030:
  - mem_read drops in cycle 1 and no i_ready is issued.
  - A d_read issued in cycle 2 is granted in cycle 2.
- Reset pulse in cycle 1 of a d_write: all outputs are 0 immediately, state is IDLE, and no d_ready is issued.
- LATENCY=1 back-to-back d_reads to 0x0001 and 0x0002 → d_ready in cycles 1 and 3, with d_rdata matching memory contents each time.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared encodings and default widths for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_LATENCY = 2;

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_ACCESS = 1'b1;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   // Counter must be able to hold LATENCY-1 for any LATENCY >= 1.
   function automatic int cnt_width(input int latency);
      return (latency < 1) ? 1 : $clog2(latency + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_grant
// Brief    : Combinational winner selection between fetch and data requests.
//            MEM_ARB_ROUND_ROBIN_EN selects alternating tie-break on last owner.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_grant (
   input  logic i_fetch_req,
   input  logic i_data_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic i_last_owner,
`endif
   output logic o_valid,
   output logic o_owner
);
   import mem_port_arbiter_pkg::*;

   assign o_valid = i_fetch_req | i_data_req;

   always_comb begin
      o_owner = i_data_req ? OWN_D : OWN_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (i_fetch_req && i_data_req) begin
         o_owner = (i_last_owner == OWN_D) ? OWN_I : OWN_D;
      end
`endif
   end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one fixed-latency memory between fetch and data ports.
//            MEM_ARB_ROUND_ROBIN_EN enables round-robin tie-breaking.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_abort,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_busy,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_busy,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = cnt_width(LATENCY);

   logic              r_state;
   logic              w_state_nxt;
   logic              r_owner;
   logic              r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_i_rdata;
   logic [DATA_W-1:0] r_d_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic              r_last_owner;
`endif

   logic w_fetch_req;
   logic w_data_req;
   logic w_grant_valid;
   logic w_grant_owner;
   logic w_last;
   logic w_fetch_abort;
   logic w_i_done;
   logic w_d_done;

   // An abort in IDLE hides the fetch from arbitration for that cycle.
   assign w_fetch_req   = i_req & ~i_abort;
   assign w_data_req    = d_read | d_write;
   assign w_last        = (r_cnt == '0);
   assign w_fetch_abort = (r_state == ST_ACCESS) && (r_owner == OWN_I) && i_abort;

   mem_arb_grant u_grant (
      .i_fetch_req  (w_fetch_req),
      .i_data_req   (w_data_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .i_last_owner (r_last_owner),
`endif
      .o_valid      (w_grant_valid),
      .o_owner      (w_grant_owner)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_grant_valid) w_state_nxt = ST_ACCESS;
         ST_ACCESS: if (w_fetch_abort || w_last) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      w_i_done  = 1'b0;
      w_d_done  = 1'b0;
      if (r_state == ST_ACCESS) begin
         mem_addr  = r_addr;
         mem_wdata = r_wdata;
         mem_read  = (r_op == OP_RD) && !w_fetch_abort;
         mem_write = (r_op == OP_WR);
         if (w_last) begin
            w_i_done = (r_owner == OWN_I) && !w_fetch_abort;
            w_d_done = (r_owner == OWN_D);
         end
      end
   end

   assign i_ready = w_i_done;
   assign d_ready = w_d_done;
   assign i_rdata = w_i_done ? mem_rdata : r_i_rdata;
   assign d_rdata = (w_d_done && (r_op == OP_RD)) ? mem_rdata : r_d_rdata;
   // Gated by reset so busy reads 0 while reset is held, even with requests up.
   assign i_busy  = ~reset & i_req & ~w_i_done;
   assign d_busy  = ~reset & w_data_req & ~w_d_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner      <= OWN_I;
         r_op         <= OP_RD;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cnt        <= '0;
         r_i_rdata    <= '0;
         r_d_rdata    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         r_last_owner <= OWN_D;
`endif
      end else begin
         if ((r_state == ST_IDLE) && w_grant_valid) begin
            r_owner      <= w_grant_owner;
            r_op         <= ((w_grant_owner == OWN_D) && d_write) ? OP_WR : OP_RD;
            r_addr       <= (w_grant_owner == OWN_D) ? d_addr : i_addr;
            r_wdata      <= ((w_grant_owner == OWN_D) && d_write) ? d_wdata : '0;
            r_cnt        <= CNT_W'(LATENCY - 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_owner <= w_grant_owner;
`endif
         end else if ((r_state == ST_ACCESS) && !w_last) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_i_done) begin
            r_i_rdata <= mem_rdata;
         end
         if (w_d_done && (r_op == OP_RD)) begin
            r_d_rdata <= mem_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed scenarios plus randomized traffic against a
//            transaction-level reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_load;
   logic        i_req, i_abort, i_ready, i_busy;
   logic [15:0] i_addr, i_rdata;
   logic        d_read, d_write, d_ready, d_busy;
   logic [15:0] d_addr, d_wdata, d_rdata;
   logic        mem_read, mem_write;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   logic        b_d_read, b_i_ready, b_i_busy, b_d_ready, b_d_busy;
   logic [15:0] b_d_addr, b_i_rdata, b_d_rdata;
   logic        b_mem_read, b_mem_write;
   logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

   logic [15:0] mem [0:255];
   logic [5:0]  obs;
   logic [5:0]  b_obs;
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] pat(input logic [7:0] k);
      if (k == 8'h10) return 16'h4A12;
      return {k ^ 8'hA5, ~k};
   endfunction

   assign mem_rdata   = mem[mem_addr[7:0]];
   assign b_mem_rdata = mem[b_mem_addr[7:0]];
   assign obs   = {i_ready, i_busy, d_ready, d_busy, mem_read, mem_write};
   assign b_obs = {b_i_ready, b_i_busy, b_d_ready, b_d_busy, b_mem_read, b_mem_write};

   always @(posedge clk) begin
      if (mem_load) begin
         for (int k = 0; k < 256; k++) mem[k] <= pat(8'(k));
      end else if (mem_write) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort),
      .i_ready(i_ready), .i_rdata(i_rdata), .i_busy(i_busy),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata), .d_busy(d_busy),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) u_dut_l1 (
      .clk(clk), .reset(reset),
      .i_req(1'b0), .i_addr(16'h0000), .i_abort(1'b0),
      .i_ready(b_i_ready), .i_rdata(b_i_rdata), .i_busy(b_i_busy),
      .d_read(b_d_read), .d_write(1'b0), .d_addr(b_d_addr), .d_wdata(16'h0000),
      .d_ready(b_d_ready), .d_rdata(b_d_rdata), .d_busy(b_d_busy),
      .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   task automatic do_reset();
      reset = 1'b1;
      i_req = 1'b0; i_abort = 1'b0; i_addr = '0;
      d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
      b_d_read = 1'b0; b_d_addr = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_fetch_only();
      logic [5:0] exp [4] = '{6'b010000, 6'b010010, 6'b100010, 6'b000000};
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         i_req  = (c < 3);
         i_addr = 16'h0010;
         @(negedge clk);
         n_cmp++;
         if (obs !== exp[c]) begin
            $display("FAIL fetch_only c%0d flags got %b want %b", c, obs, exp[c]); n_fail++;
         end
         if (c == 1) begin
            n_cmp++;
            if (mem_addr !== 16'h0010) begin
               $display("FAIL fetch_only mem_addr got %h want 0010", mem_addr); n_fail++;
            end
         end
         if (c >= 2) begin
            n_cmp++;
            if (i_rdata !== 16'h4A12) begin
               $display("FAIL fetch_only c%0d i_rdata got %h want 4a12", c, i_rdata); n_fail++;
            end
         end
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      reset = 1'b1; i_req = 1'b1; i_addr = 16'h0010;
      d_write = 1'b1; d_addr = 16'h0001; d_wdata = 16'hFFFF;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({obs, b_obs} !== 12'h000) begin
            $display("FAIL reset c%0d flags got %b_%b want 0", c, obs, b_obs); n_fail++;
         end
         n_cmp++;
         if ({i_rdata, d_rdata} !== 32'h0) begin
            $display("FAIL reset rdata got %h/%h want 0/0", i_rdata, d_rdata); n_fail++;
         end
         n_cmp++;
         if ({mem_addr, mem_wdata} !== 32'h0) begin
            $display("FAIL reset mem bus got %h/%h want 0/0", mem_addr, mem_wdata); n_fail++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_tie();
      logic [5:0] exp [6];
      int         i_end, d_end, ir_c;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp = '{6'b010100, 6'b010110, 6'b100110, 6'b000100, 6'b000101, 6'b001001};
      i_end = 3; d_end = 6; ir_c = 2;
`else
      exp = '{6'b010100, 6'b010101, 6'b011001, 6'b010000, 6'b010010, 6'b100010};
      i_end = 6; d_end = 3; ir_c = 5;
`endif
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         i_req = (c < i_end); i_addr = 16'h0020;
         d_write = (c < d_end); d_addr = 16'h0100; d_wdata = 16'hBEEF;
         @(negedge clk);
         n_cmp++;
         if (obs !== exp[c]) begin
            $display("FAIL tie c%0d flags got %b want %b", c, obs, exp[c]); n_fail++;
         end
         if (exp[c][0]) begin
            n_cmp++;
            if ({mem_addr, mem_wdata} !== {16'h0100, 16'hBEEF}) begin
               $display("FAIL tie write bus got %h/%h want 0100/beef", mem_addr, mem_wdata); n_fail++;
            end
         end
         if (c == ir_c) begin
            n_cmp++;
            if (i_rdata !== pat(8'h20)) begin
               $display("FAIL tie i_rdata got %h want %h", i_rdata, pat(8'h20)); n_fail++;
            end
         end
      end
      @(posedge clk); #1;
      i_req = 1'b0; d_write = 1'b0;
      n_cmp++;
      if (mem[0] !== 16'hBEEF) begin
         $display("FAIL tie mem[0100] got %h want beef", mem[0]); n_fail++;
      end
   endtask

   task automatic test_abort();
      logic [5:0] exp [5] = '{6'b010000, 6'b010000, 6'b000100, 6'b000110, 6'b001010};
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         i_req = (c < 2); i_addr = 16'h0030; i_abort = (c == 1);
         d_read = (c >= 2); d_addr = 16'h0040;
         @(negedge clk);
         n_cmp++;
         if (obs !== exp[c]) begin
            $display("FAIL abort c%0d flags got %b want %b", c, obs, exp[c]); n_fail++;
         end
         if (c == 3) begin
            n_cmp++;
            if (mem_addr !== 16'h0040) begin
               $display("FAIL abort mem_addr got %h want 0040", mem_addr); n_fail++;
            end
         end
         if (c == 4) begin
            n_cmp++;
            if (d_rdata !== pat(8'h40)) begin
               $display("FAIL abort d_rdata got %h want %h", d_rdata, pat(8'h40)); n_fail++;
            end
         end
      end
      @(posedge clk); #1;
      d_read = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(posedge clk); #1;
      d_write = 1'b1; d_addr = 16'h0055; d_wdata = 16'h1234;
      @(posedge clk); #2;
      n_cmp++;
      if (obs !== 6'b000101) begin
         $display("FAIL reset_mid pre flags got %b want 000101", obs); n_fail++;
      end
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if ({obs, mem_addr, mem_wdata} !== 38'h0) begin
         $display("FAIL reset_mid flags/bus got %b %h %h want 0", obs, mem_addr, mem_wdata); n_fail++;
      end
      #2 reset = 1'b0; d_write = 1'b0;
      for (int c = 2; c < 4; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_cmp++;
         if (obs !== 6'b000000) begin
            $display("FAIL reset_mid c%0d flags got %b want 0", c, obs); n_fail++;
         end
      end
      n_cmp++;
      if (mem[8'h55] !== pat(8'h55)) begin
         $display("FAIL reset_mid mem[55] got %h want %h", mem[8'h55], pat(8'h55)); n_fail++;
      end
   endtask

   task automatic test_latency1();
      logic [5:0] exp [5] = '{6'b000100, 6'b001010, 6'b000100, 6'b001010, 6'b000000};
      logic [15:0] rd;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         b_d_read = (c < 4);
         b_d_addr = (c < 2) ? 16'h0001 : 16'h0002;
         @(negedge clk);
         n_cmp++;
         if (b_obs !== exp[c]) begin
            $display("FAIL lat1 c%0d flags got %b want %b", c, b_obs, exp[c]); n_fail++;
         end
         if (c >= 1) begin
            rd = (c < 3) ? pat(8'h01) : pat(8'h02);
            n_cmp++;
            if (b_d_rdata !== rd) begin
               $display("FAIL lat1 c%0d d_rdata got %h want %h", c, b_d_rdata, rd); n_fail++;
            end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] rm [256];
      bit          act, own_d, is_wr, last_d, fp, dp, ab, dr, dw, fq;
      bit          e_ir, e_dr, e_rd, e_wr;
      int          g, k;
      logic [15:0] a, wd, fa, da, dwd, exp_ir, exp_dr;
      logic [5:0]  e_obs;
      do_reset();
      for (int j = 0; j < 256; j++) rm[j] = mem[j];
      act = 0; last_d = 1; fp = 0; dp = 0; g = 0;
      own_d = 0; is_wr = 0; dr = 0; dw = 0;
      a = '0; wd = '0; fa = '0; da = '0; dwd = '0; exp_ir = '0; exp_dr = '0;
      for (int t = 0; t < 600; t++) begin
         @(posedge clk); #1;
         if (!fp && $urandom_range(0, 2) == 0) begin
            fp = 1; fa = 16'($urandom);
         end
         ab = ($urandom_range(0, 9) == 0);
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1; k = int'($urandom_range(0, 7));
            dr = (k < 4) || (k == 7); dw = (k >= 4);
            da = 16'($urandom); dwd = 16'($urandom);
         end
         i_req = fp; i_addr = fa; i_abort = ab;
         d_read = dp && dr; d_write = dp && dw; d_addr = da; d_wdata = dwd;

         e_ir = 0; e_dr = 0; e_rd = 0; e_wr = 0;
         if (act) begin
            if (!own_d && ab) begin
               act = 0;
            end else begin
               e_rd = !is_wr; e_wr = is_wr;
               if (t == g + LAT) begin
                  act = 0;
                  if (own_d && is_wr) rm[a[7:0]] = wd;
                  else if (own_d) begin e_dr = 1; exp_dr = rm[a[7:0]]; end
                  else begin e_ir = 1; exp_ir = rm[a[7:0]]; end
                  if (own_d) e_dr = 1;
               end
            end
         end else begin
            fq = fp && !ab;
            if (fq || dp) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
               own_d = dp && !(fq && last_d);
`else
               own_d = dp;
`endif
               last_d = own_d; act = 1; g = t;
               is_wr = own_d && dw;
               a = own_d ? da : fa; wd = dwd;
            end
         end
         e_obs = {e_ir, fp && !e_ir, e_dr, dp && !e_dr, e_rd, e_wr};

         @(negedge clk);
         n_cmp++;
         if (obs !== e_obs) begin
            $display("FAIL rand t%0d flags got %b want %b", t, obs, e_obs); n_fail++;
         end
         n_cmp++;
         if ({i_rdata, d_rdata} !== {exp_ir, exp_dr}) begin
            $display("FAIL rand t%0d rdata got %h/%h want %h/%h", t, i_rdata, d_rdata, exp_ir, exp_dr); n_fail++;
         end
         if (e_rd || e_wr) begin
            n_cmp++;
            if (mem_addr !== a || (e_wr && mem_wdata !== wd)) begin
               $display("FAIL rand t%0d bus got %h/%h want %h/%h", t, mem_addr, mem_wdata, a, wd); n_fail++;
            end
         end
         if (e_ir || ab) fp = 0;
         if (e_dr) dp = 0;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_load = 1'b1;
      do_reset();
      mem_load = 1'b0;
      test_fetch_only();
      test_reset();
      test_tie();
      test_abort();
      test_reset_mid();
      test_latency1();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
